// File: rtl/remote_comm.sv
// Remote command link: sends {cmd, data_hi, data_lo} as three 8N1 UART bytes,
// then waits for a one-byte response or a timeout.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter bit          FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        TX,
  output logic        busy,
  output logic        cmd_cmplt,
  output logic        resp_ok,
  output logic        timeout
);

  localparam int unsigned TMO    = FAST_SIM ? 512 : (1 << 26);
  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned WAIT_W = 26;
  localparam logic [7:0]  ACK    = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_HI,
    SEND_LO,
    WAIT_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [23:0]         frame_q, frame_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                cmplt_q, cmplt_d;
  logic                ok_q, ok_d;
  logic                tmo_q, tmo_d;
  logic [7:0]          cur_byte;

  // State and output registers; reset parks the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      wait_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      cmplt_q <= 1'b0;
      ok_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      wait_q  <= wait_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      cmplt_q <= cmplt_d;
      ok_q    <= ok_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: bit timing, byte sequencing and response handling.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    wait_d   = wait_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    cmplt_d  = 1'b0;
    ok_d     = ok_q;
    tmo_d    = tmo_q;
    cur_byte = 8'h00;

    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          frame_d = {cmd, data};
          ok_d    = 1'b0;
          tmo_d   = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SEND_CMD;
        end
      end

      SEND_CMD, SEND_HI, SEND_LO: begin
        if (state_q == SEND_CMD)     cur_byte = frame_q[23:16];
        else if (state_q == SEND_HI) cur_byte = frame_q[15:8];
        else                         cur_byte = frame_q[7:0];

        if (baud_q == BAUD_W'(BAUD_DIV - 1)) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            // Stop bit done: start the next byte immediately or go wait.
            bit_d = '0;
            if (state_q == SEND_CMD) begin
              state_d = SEND_HI;
              tx_d    = 1'b0;
            end else if (state_q == SEND_HI) begin
              state_d = SEND_LO;
              tx_d    = 1'b0;
            end else begin
              state_d = WAIT_RESP;
              tx_d    = 1'b1;
              wait_d  = '0;
            end
          end else begin
            // Bit 0 is start; bits 1..8 are data LSB first; bit 9 is stop.
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      WAIT_RESP: begin
        wait_d = wait_q + WAIT_W'(1);
        if (resp_rdy) begin
          cmplt_d = 1'b1;
          ok_d    = (resp == ACK);
          busy_d  = 1'b0;
          wait_d  = '0;
          state_d = IDLE;
        end else if (wait_q == WAIT_W'(TMO - 1)) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          wait_d  = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX        = tx_q;
  assign busy      = busy_q;
  assign cmd_cmplt = cmplt_q;
  assign resp_ok   = ok_q;
  assign timeout   = tmo_q;

endmodule
